minmax_window_tracker: RTL and testbench
========================================

Name: minmax_window_tracker

Overview:
- Streaming consumer of N-bit samples. Tracks the running minimum and maximum over fixed windows of WIN accepted samples, then presents one result per window.
- Sits directly downstream of the N-bit magnitude comparator. Instantiates that comparator twice, using A_gt_B, A_lt_B and A_eq_B for the min/max update decisions.
- Valid/ready handshake on both input and output; backpressure from the output stalls the input.

Parameters:
- N, 4, sample width in bits.
- WIN, 4, samples per window; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  synchronous flush of the partial window and any pending result.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  unsigned sample.
- out_valid  output  1  window result present.
- out_ready  input  1  downstream takes the result.
- out_min  output  N  minimum of the window.
- out_max  output  N  maximum of the window.
- out_all_eq  output  1  all WIN samples were equal.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: while rst=1 at a clock edge, all state is cleared and the FSM goes to EMPTY. Outputs after reset: out_valid=0, out_min=0, out_max=0, out_all_eq=0, in_ready=1.
- Accept and deliver: a sample is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Arithmetic: unsigned compares only. Sample counter width is $clog2(WIN+1).
- State EMPTY:
  - in_ready=1.
  - On accept: min=max=in_data, cnt=1, eq=1, go to ACCUM.
- State ACCUM:
  - in_ready=1.
  - On accept: if in_data < min then min=in_data. If in_data > max then max=in_data. If in_data != min then eq=0. cnt++.
  - Ties are strict: the first occurrence is retained.
  - When the accepted sample makes cnt==WIN: go to HOLD, registering out_min/out_max/out_all_eq and asserting out_valid.
- Latency: out_valid rises the cycle after the WIN-th sample is accepted.
- State HOLD:
  - out_valid=1; out_* are stable until delivered.
  - in_ready = out_ready (combinational pass-through).
  - Delivery without accept: out_valid=0, go to EMPTY.
  - Delivery with accept in the same cycle: the accepted sample becomes the first sample of the new window (min=max=in_data, cnt=1), go to ACCUM. No bubble.
- clear:
  - Priority: below rst, above all other events.
  - Next state is EMPTY, cnt=0, out_valid=0. A pending result is discarded.
  - A sample presented in the same cycle as clear is not accepted (in_ready is forced to 0 while clear=1).
- Boundaries:
  - A sample equal to the current min/max changes nothing except cnt.
  - out_* hold their last delivered values while out_valid=0.
  - rst mid-window discards everything.

Optional Feature:
- Macro: MINMAX_ARGIDX_EN.
- When defined, adds two outputs, out_min_idx and out_max_idx, each $clog2(WIN) bits. Each holds the 0-based position within the window of the first occurrence of the min/max. Both reset to 0 and follow the same hold and clear rules as out_min/out_max.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package minmax_pkg holds:
  - the FSM state typedef: EMPTY, ACCUM, HOLD (2-bit encoding);
  - the counter-width function (clog2 helper).
- Sub-module: the existing comparator, instantiated twice: in_data vs min, and in_data vs max. No new sub-module.

Test Plan:
- Mixed window: WIN=4, N=4, samples 3,9,5,1 with out_ready=1 → one cycle after the 4th accept, out_valid=1, out_min=1, out_max=9, out_all_eq=0.
- Equal window: 5,5,5,5 → out_min=5, out_max=5, out_all_eq=1.
- Backpressure:
  - After a window completes, hold out_ready=0 for 3 cycles → in_ready=0 and out_* stable throughout.
  - Then out_ready=1 with in_valid=1, in_data=7 → result delivered and 7 accepted in the same cycle.
  - Next samples 2,12,4 → out_min=2, out_max=12.
- Clear: accept 15,0, assert clear for 1 cycle, then 6,8,7,6 → out_min=6, out_max=8 (15 and 0 absent).
- Reset mid-window: accept 2 samples, pulse rst → out_valid=0, out_min=0, out_max=0. The following 4 samples form a complete fresh window.
- MINMAX_ARGIDX_EN defined: samples 4,2,8,2 → out_min=2, out_min_idx=1, out_max=8, out_max_idx=2.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max window tracker: FSM state encoding
// and the width helpers used to size the sample counter and index fields.
package minmax_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 32'd0;
    span  = 32'd1;
    while (span < value) begin
      span  = span << 32'd1;
      width = width + 32'd1;
    end
    return width;
  endfunction

  // Counter must be able to hold the value WIN itself.
  function automatic int unsigned cnt_width_f(input int unsigned win);
    return clog2_f(win + 32'd1);
  endfunction

endpackage

// File: rtl/minmax_window_tracker_if.sv
// Handshake bundle between the sample producer, the min/max window tracker
// and the result consumer. Index outputs exist only with MINMAX_ARGIDX_EN.
interface minmax_window_tracker_if #(
  parameter int N = 4
`ifdef MINMAX_ARGIDX_EN
  , parameter int IDX_W = 2
`endif
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_min;
  logic [N-1:0] out_max;
  logic         out_all_eq;
`ifdef MINMAX_ARGIDX_EN
  logic [IDX_W-1:0] out_min_idx;
  logic [IDX_W-1:0] out_max_idx;
`endif

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_max,
`ifdef MINMAX_ARGIDX_EN
    input  out_min_idx, out_max_idx,
`endif
    input  out_all_eq
  );

  // Tracker side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_max,
`ifdef MINMAX_ARGIDX_EN
    output out_min_idx, out_max_idx,
`endif
    output out_all_eq
  );

endinterface

// File: rtl/minmax_window_tracker_cmp.sv
// N-bit unsigned magnitude comparator: exactly one of A_gt_B, A_lt_B,
// A_eq_B is high for any pair of inputs.
module minmax_window_tracker_cmp #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         A_gt_B,
  output logic         A_lt_B,
  output logic         A_eq_B
);

  assign A_gt_B = (A > B);
  assign A_lt_B = (A < B);
  assign A_eq_B = (A == B);

endmodule

// File: rtl/minmax_window_tracker.sv
// Min/max window tracker: consumes a valid/ready stream of unsigned N-bit
// samples and emits min, max and an all-equal flag for every WIN accepted
// samples. A pending result backpressures the input until it is taken;
// delivery and the first sample of the next window may share a cycle.
// Optional feature macro: MINMAX_ARGIDX_EN adds out_min_idx/out_max_idx,
// the window position of the first occurrence of the min/max.
module minmax_window_tracker
  import minmax_pkg::*;
#(
  parameter int N   = 4,
  parameter int WIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  minmax_window_tracker_if.slave bus
);

  localparam int CNT_W = int'(cnt_width_f(WIN));
`ifdef MINMAX_ARGIDX_EN
  localparam int IDX_W = int'(clog2_f(WIN));
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [N-1:0]       min_r;
  logic [N-1:0]       max_r;
  logic               eq_r;
  logic               out_valid_r;
  logic [N-1:0]       out_min_r;
  logic [N-1:0]       out_max_r;
  logic               out_all_eq_r;
`ifdef MINMAX_ARGIDX_EN
  logic [IDX_W-1:0]   min_idx_r;
  logic [IDX_W-1:0]   max_idx_r;
  logic [IDX_W-1:0]   out_min_idx_r;
  logic [IDX_W-1:0]   out_max_idx_r;
  logic [IDX_W-1:0]   acc_min_idx_s;
  logic [IDX_W-1:0]   acc_max_idx_s;
`endif

  // Control strobes from the FSM to the datapath
  logic               in_ready_s;
  logic               start_s;
  logic               accum_s;
  logic               finish_s;

  // Comparator results and running-window candidates
  logic               min_gt_s;
  logic               min_lt_s;
  logic               min_eq_s;
  logic               max_gt_s;
  logic               max_lt_s;
  logic               max_eq_s;
  logic               last_s;
  logic [N-1:0]       acc_min_s;
  logic [N-1:0]       acc_max_s;
  logic               acc_eq_s;
  logic               unused_cmp_s;

  minmax_window_tracker_cmp #(.N(N)) u_cmp_min (
    .A      (bus.in_data),
    .B      (min_r),
    .A_gt_B (min_gt_s),
    .A_lt_B (min_lt_s),
    .A_eq_B (min_eq_s)
  );

  minmax_window_tracker_cmp #(.N(N)) u_cmp_max (
    .A      (bus.in_data),
    .B      (max_r),
    .A_gt_B (max_gt_s),
    .A_lt_B (max_lt_s),
    .A_eq_B (max_eq_s)
  );

  // Only strict less-than on min and strict greater-than on max move the
  // extremes, so ties keep the first occurrence. While all samples so far
  // are equal min==max, so a sample must match both to keep the flag.
  assign unused_cmp_s = min_gt_s | max_lt_s;
  assign acc_min_s    = min_lt_s ? bus.in_data : min_r;
  assign acc_max_s    = max_gt_s ? bus.in_data : max_r;
  assign acc_eq_s     = eq_r & min_eq_s & max_eq_s;
  assign cnt_inc_s    = cnt_r + CNT_W'(1);
  assign last_s       = (cnt_inc_s == CNT_W'(WIN));
`ifdef MINMAX_ARGIDX_EN
  // cnt_r is the 0-based position of the sample being accepted
  assign acc_min_idx_s = min_lt_s ? IDX_W'(cnt_r) : min_idx_r;
  assign acc_max_idx_s = max_gt_s ? IDX_W'(cnt_r) : max_idx_r;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, input readiness and datapath strobes; clear overrides all
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    start_s     = 1'b0;
    accum_s     = 1'b0;
    finish_s    = 1'b0;
    if (clear) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            start_s     = 1'b1;
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ACCUM: begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            accum_s = 1'b1;
            if (last_s) begin
              finish_s    = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = ACCUM;
            end
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        HOLD: begin
          in_ready_s = bus.out_ready;
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              start_s     = 1'b1;
              state_nxt_s = ACCUM;
            end else begin
              state_nxt_s = EMPTY;
            end
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Window accumulators, sample counter and the registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= {CNT_W{1'b0}};
      min_r         <= {N{1'b0}};
      max_r         <= {N{1'b0}};
      eq_r          <= 1'b0;
      out_valid_r   <= 1'b0;
      out_min_r     <= {N{1'b0}};
      out_max_r     <= {N{1'b0}};
      out_all_eq_r  <= 1'b0;
`ifdef MINMAX_ARGIDX_EN
      min_idx_r     <= {IDX_W{1'b0}};
      max_idx_r     <= {IDX_W{1'b0}};
      out_min_idx_r <= {IDX_W{1'b0}};
      out_max_idx_r <= {IDX_W{1'b0}};
`endif
    end else begin
      out_valid_r <= (state_nxt_s == HOLD);
      if (clear) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (start_s) begin
        cnt_r     <= CNT_W'(1);
        min_r     <= bus.in_data;
        max_r     <= bus.in_data;
        eq_r      <= 1'b1;
`ifdef MINMAX_ARGIDX_EN
        min_idx_r <= {IDX_W{1'b0}};
        max_idx_r <= {IDX_W{1'b0}};
`endif
      end else if (accum_s) begin
        cnt_r     <= cnt_inc_s;
        min_r     <= acc_min_s;
        max_r     <= acc_max_s;
        eq_r      <= acc_eq_s;
`ifdef MINMAX_ARGIDX_EN
        min_idx_r <= acc_min_idx_s;
        max_idx_r <= acc_max_idx_s;
`endif
      end else begin
        cnt_r <= cnt_r;
      end
      if (finish_s) begin
        out_min_r     <= acc_min_s;
        out_max_r     <= acc_max_s;
        out_all_eq_r  <= acc_eq_s;
`ifdef MINMAX_ARGIDX_EN
        out_min_idx_r <= acc_min_idx_s;
        out_max_idx_r <= acc_max_idx_s;
`endif
      end else begin
        out_min_r <= out_min_r;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_min     = out_min_r;
  assign bus.out_max     = out_max_r;
  assign bus.out_all_eq  = out_all_eq_r;
`ifdef MINMAX_ARGIDX_EN
  assign bus.out_min_idx = out_min_idx_r;
  assign bus.out_max_idx = out_max_idx_r;
`endif

endmodule

// File: tb/tb_minmax_window_tracker.sv
// Self-checking bench for minmax_window_tracker: directed windows followed
// by randomized traffic, all compared against a queue-based window model.
module tb_minmax_window_tracker;

  localparam int N     = 4;
  localparam int WIN   = 4;
  localparam int IDX_W = $clog2(WIN);

  logic clk;
  logic rst;
  logic clear;

`ifdef MINMAX_ARGIDX_EN
  minmax_window_tracker_if #(.N(N), .IDX_W(IDX_W)) bus ();
`else
  minmax_window_tracker_if #(.N(N)) bus ();
`endif

  minmax_window_tracker #(.N(N), .WIN(WIN)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  // Reference model state
  logic [N-1:0] win_q[$];
  bit           m_pend;
  int           m_min;
  int           m_max;
  int           m_eq;
  int           m_min_idx;
  int           m_max_idx;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window result from first principles
  task automatic model_close_window();
    m_min = int'(win_q[0]);
    m_max = int'(win_q[0]);
    m_eq  = 1;
    m_min_idx = 0;
    m_max_idx = 0;
    for (int i = 0; i < win_q.size(); i++) begin
      if (int'(win_q[i]) < m_min) begin m_min = int'(win_q[i]); m_min_idx = i; end
      if (int'(win_q[i]) > m_max) begin m_max = int'(win_q[i]); m_max_idx = i; end
      if (win_q[i] != win_q[0]) m_eq = 0;
    end
    m_pend = 1'b1;
    win_q.delete();
  endtask

  task automatic check_outputs();
    check_val("out_valid", 32'(bus.out_valid), 32'(m_pend));
    if (m_pend) begin
      check_val("out_min", 32'(bus.out_min), 32'(m_min));
      check_val("out_max", 32'(bus.out_max), 32'(m_max));
      check_val("out_all_eq", 32'(bus.out_all_eq), 32'(m_eq));
`ifdef MINMAX_ARGIDX_EN
      check_val("out_min_idx", 32'(bus.out_min_idx), 32'(m_min_idx));
      check_val("out_max_idx", 32'(bus.out_max_idx), 32'(m_max_idx));
`endif
    end
  endtask

  // One clock cycle of stimulus with model update
  task automatic step(input bit v, input logic [N-1:0] d, input bit ordy, input bit clr);
    bit exp_rdy;
    bit deliver;
    bit accept;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    exp_rdy = !clr && (!m_pend || ordy);
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (clr) begin
      win_q.delete();
      m_pend = 1'b0;
    end else begin
      deliver = m_pend && ordy;
      accept  = v && exp_rdy;
      if (deliver) m_pend = 1'b0;
      if (accept) begin
        win_q.push_back(d);
        if (win_q.size() == WIN) model_close_window();
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    win_q.delete();
    m_pend = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_min", 32'(bus.out_min), 32'd0);
    check_val("rst_out_max", 32'(bus.out_max), 32'd0);
    check_val("rst_out_all_eq", 32'(bus.out_all_eq), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef MINMAX_ARGIDX_EN
    check_val("rst_out_min_idx", 32'(bus.out_min_idx), 32'd0);
    check_val("rst_out_max_idx", 32'(bus.out_max_idx), 32'd0);
`endif
  endtask

  task automatic feed(input int a, input int b, input int c, input int e);
    step(1'b1, N'(a), 1'b1, 1'b0);
    step(1'b1, N'(b), 1'b1, 1'b0);
    step(1'b1, N'(c), 1'b1, 1'b0);
    step(1'b1, N'(e), 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    do_reset();

    // Mixed window, then deliver
    feed(3, 9, 5, 1);
    step(1'b0, '0, 1'b1, 1'b0);

    // All-equal window
    feed(5, 5, 5, 5);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: result held for 3 cycles, then delivery with accept of 7
    feed(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) step(1'b1, N'($urandom), 1'b0, 1'b0);
    step(1'b1, N'(7), 1'b1, 1'b0);
    step(1'b1, N'(2), 1'b1, 1'b0);
    step(1'b1, N'(12), 1'b1, 1'b0);
    step(1'b1, N'(4), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear drops the partial window; sample presented with clear is refused
    step(1'b1, N'(15), 1'b1, 1'b0);
    step(1'b1, N'(0), 1'b1, 1'b0);
    step(1'b1, N'(3), 1'b1, 1'b1);
    feed(6, 8, 7, 6);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-window, then a fresh full window
    step(1'b1, N'(11), 1'b1, 1'b0);
    step(1'b1, N'(13), 1'b1, 1'b0);
    do_reset();
    feed(1, 14, 1, 14);
    step(1'b0, '0, 1'b1, 1'b0);

    // Ties keep the first occurrence
    feed(4, 2, 8, 2);
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear while a result is pending
    feed(9, 3, 3, 9);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, N'(5), 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), N'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
